// File: rtl/pipelined_cla_subtractor.sv
// Pipelined two's-complement subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin with one ripple-within-group CLA group resolved per stage
// and the group carry registered between stages.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand beat handshake (a, b, bin)
//   out_valid/out_ready result handshake (diff, bout, ovf)
//   diff              a - b - bin modulo 2^DATA_WIDTH (or saturated)
//   bout              borrow-out, 1 when unsigned a < b + bin
//   ovf               signed overflow of the raw difference
//
// Build option: define CLA_SUB_SATURATE_EN to clamp diff to the signed
// limits on overflow; otherwise diff wraps.
//
// Pipeline: an operand capture rank followed by NUM_GROUPS compute stages,
// the last of which is the output register, so a beat accepted on edge t
// is presented after edge t+NUM_GROUPS. The whole pipe stalls together.
module pipelined_cla_subtractor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GROUP_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bout,
    output logic                  ovf
);

    localparam int unsigned NUM_GROUPS = (DATA_WIDTH + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int unsigned LAST_W     = DATA_WIDTH - (NUM_GROUPS - 1) * GROUP_SIZE;

    logic advance;

    // Global stall: everything moves only when the output slot can be filled.
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // Operand capture rank: a, inverted subtrahend, inverted borrow as carry-in.
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] nb_q;
    logic                  c0_q;
    logic                  v0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            nb_q <= '0;
            c0_q <= 1'b0;
            v0_q <= 1'b0;
        end else if (advance) begin
            a_q  <= a;
            nb_q <= ~b;
            c0_q <= !bin;
            v0_q <= in_valid;
        end
    end

    for (genvar k = 0; k < int'(NUM_GROUPS); k++) begin : g_stage
        localparam bit          IS_LAST = (k == int'(NUM_GROUPS) - 1);
        localparam int unsigned LO      = k * GROUP_SIZE;
        localparam int unsigned GW      = IS_LAST ? LAST_W : GROUP_SIZE;
        localparam int unsigned REM_IN  = DATA_WIDTH - LO;

        // work_in holds resolved diff bits below LO and raw a bits from LO up;
        // nb_in holds only the still-unresolved ~b bits starting at LO.
        logic [DATA_WIDTH-1:0] work_in;
        logic [REM_IN-1:0]     nb_in;
        logic                  c_in;
        logic                  v_in;
        logic [GW-1:0]         grp_sum;
        logic                  c_out;
        logic [DATA_WIDTH-1:0] work_nxt;

        if (k == 0) begin : g_src
            assign work_in = a_q;
            assign nb_in   = nb_q;
            assign c_in    = c0_q;
            assign v_in    = v0_q;
        end else begin : g_src
            assign work_in = g_stage[k-1].g_reg.work_q;
            assign nb_in   = g_stage[k-1].g_reg.nb_q;
            assign c_in    = g_stage[k-1].g_reg.c_q;
            assign v_in    = g_stage[k-1].g_reg.v_q;
        end

        // Resolve this group: ripple generate/propagate within the group.
        always_comb begin : p_group
            logic c;
            c       = c_in;
            grp_sum = '0;
            for (int i = 0; i < int'(GW); i++) begin
                grp_sum[i] = work_in[LO + i] ^ nb_in[i] ^ c;
                c = (work_in[LO + i] & nb_in[i]) | ((work_in[LO + i] ^ nb_in[i]) & c);
            end
            c_out    = c;
            work_nxt = work_in;
            work_nxt[LO +: GW] = grp_sum;
        end

        if (!IS_LAST) begin : g_reg
            localparam int unsigned REM_OUT = REM_IN - GW;

            logic [DATA_WIDTH-1:0] work_q;
            logic [REM_OUT-1:0]    nb_q;
            logic                  c_q;
            logic                  v_q;

            // Inter-stage register; consumed ~b bits are dropped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    work_q <= '0;
                    nb_q   <= '0;
                    c_q    <= 1'b0;
                    v_q    <= 1'b0;
                end else if (advance) begin
                    work_q <= work_nxt;
                    nb_q   <= nb_in[REM_IN-1:GW];
                    c_q    <= c_out;
                    v_q    <= v_in;
                end
            end
        end else begin : g_out
            logic                  a_sign;
            logic                  b_sign;
            logic                  ovf_c;
            logic [DATA_WIDTH-1:0] res_c;

            // Overflow detect and optional saturation on the final group.
            always_comb begin
                a_sign = work_in[DATA_WIDTH-1];
                b_sign = !nb_in[GW-1];
                ovf_c  = (a_sign != b_sign) && (work_nxt[DATA_WIDTH-1] != a_sign);
                res_c  = work_nxt;
`ifdef CLA_SUB_SATURATE_EN
                if (ovf_c) begin
                    res_c = a_sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
`endif
            end

            // Output register; data only loads on a valid beat so idle
            // outputs keep their reset value until the first result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    diff      <= '0;
                    bout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_in;
                    if (v_in) begin
                        diff <= res_c;
                        bout <= !c_out;
                        ovf  <= ovf_c;
                    end
                end
            end
        end
    end

endmodule
